// File: rtl/cascade_systolic_fir.sv
`default_nettype none
// ============================================================================
// Module      : cascade_systolic_fir
// Description : 5x5 two-dimensional FIR over a video stream, built as a
//               systolic cascade. One image column (pixel0..pixel4, one pixel
//               per window row) is taken every clock into free-running
//               per-row column shift registers. Each of the 25 window taps is
//               multiplied by a signed Q8.8 coefficient in a registered
//               multiplier. Each row sums its products through a two-step
//               cascaded adder chain. The five row sums are combined in a
//               registered stage. A last registered stage shifts right by 8
//               and saturates the result to 0..255.
//               The latency from the sampling edge to out_pixel is 5 edges.
//               The sideband signals go through registers of the same depth.
// Ports       : clk, rst               - clock, async active-high reset
//               in_valid               - column qualifier (affects out_valid only)
//               dv_i, hs_i, vs_i       - video sideband in
//               pixel0..pixel4 [7:0]   - unsigned column, pixelR = row R
//               coeff00..coeff44[15:0] - signed Q8.8, coeffRC = row R, column C
//               out_valid              - qualifier aligned with out_pixel
//               dv_o, hs_o, vs_o       - delayed sideband
//               out_pixel [7:0]        - saturated filtered pixel
// Revision    : 1.0 - initial release
// ============================================================================
module cascade_systolic_fir (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        dv_i,
    input  logic        hs_i,
    input  logic        vs_i,
    input  logic [7:0]  pixel0,
    input  logic [7:0]  pixel1,
    input  logic [7:0]  pixel2,
    input  logic [7:0]  pixel3,
    input  logic [7:0]  pixel4,
    input  logic [15:0] coeff00, coeff01, coeff02, coeff03, coeff04,
    input  logic [15:0] coeff10, coeff11, coeff12, coeff13, coeff14,
    input  logic [15:0] coeff20, coeff21, coeff22, coeff23, coeff24,
    input  logic [15:0] coeff30, coeff31, coeff32, coeff33, coeff34,
    input  logic [15:0] coeff40, coeff41, coeff42, coeff43, coeff44,
    output logic        out_valid,
    output logic        dv_o,
    output logic        hs_o,
    output logic        vs_o,
    output logic [7:0]  out_pixel
);

    localparam int c_N = 5;

    // ------------------------------------------------------------------
    // Port regrouping: index [row][col]
    // ------------------------------------------------------------------
    logic        [7:0]  w_pix   [c_N];
    logic signed [15:0] w_coeff [c_N][c_N];

    assign w_pix[0] = pixel0;
    assign w_pix[1] = pixel1;
    assign w_pix[2] = pixel2;
    assign w_pix[3] = pixel3;
    assign w_pix[4] = pixel4;

    assign w_coeff[0][0] = coeff00; assign w_coeff[0][1] = coeff01; assign w_coeff[0][2] = coeff02;
    assign w_coeff[0][3] = coeff03; assign w_coeff[0][4] = coeff04;
    assign w_coeff[1][0] = coeff10; assign w_coeff[1][1] = coeff11; assign w_coeff[1][2] = coeff12;
    assign w_coeff[1][3] = coeff13; assign w_coeff[1][4] = coeff14;
    assign w_coeff[2][0] = coeff20; assign w_coeff[2][1] = coeff21; assign w_coeff[2][2] = coeff22;
    assign w_coeff[2][3] = coeff23; assign w_coeff[2][4] = coeff24;
    assign w_coeff[3][0] = coeff30; assign w_coeff[3][1] = coeff31; assign w_coeff[3][2] = coeff32;
    assign w_coeff[3][3] = coeff33; assign w_coeff[3][4] = coeff34;
    assign w_coeff[4][0] = coeff40; assign w_coeff[4][1] = coeff41; assign w_coeff[4][2] = coeff42;
    assign w_coeff[4][3] = coeff43; assign w_coeff[4][4] = coeff44;

    // ------------------------------------------------------------------
    // Window column shift registers; column 4 holds the newest sample.
    // ------------------------------------------------------------------
    logic [7:0] r_win [c_N][c_N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < c_N; r++)
                for (int c = 0; c < c_N; c++)
                    r_win[r][c] <= '0;
        end else begin
            for (int r = 0; r < c_N; r++) begin
                for (int c = 0; c < c_N - 1; c++)
                    r_win[r][c] <= r_win[r][c+1];
                r_win[r][c_N-1] <= w_pix[r];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: registered multiplies. The pixel gets a zero sign bit so
    // that a 9x16 signed product fits exactly in 25 bits.
    // ------------------------------------------------------------------
    logic signed [24:0] r_prod [c_N][c_N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < c_N; r++)
                for (int c = 0; c < c_N; c++)
                    r_prod[r][c] <= '0;
        end else begin
            for (int r = 0; r < c_N; r++)
                for (int c = 0; c < c_N; c++)
                    r_prod[r][c] <= $signed({1'b0, r_win[r][c]}) * w_coeff[r][c];
        end
    end

    // ------------------------------------------------------------------
    // Stages 2-3: per-row cascaded adder chain. Columns 0..2 are summed
    // first. Columns 3 and 4 wait one register and are then added into
    // the partial sum. A row sum of five 25-bit terms needs 28 bits.
    // ------------------------------------------------------------------
    logic signed [26:0] r_part [c_N];
    logic signed [24:0] r_p3   [c_N];
    logic signed [24:0] r_p4   [c_N];
    logic signed [27:0] r_row  [c_N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < c_N; r++) begin
                r_part[r] <= '0;
                r_p3[r]   <= '0;
                r_p4[r]   <= '0;
                r_row[r]  <= '0;
            end
        end else begin
            for (int r = 0; r < c_N; r++) begin
                r_part[r] <= 27'(r_prod[r][0]) + 27'(r_prod[r][1]) + 27'(r_prod[r][2]);
                r_p3[r]   <= r_prod[r][3];
                r_p4[r]   <= r_prod[r][4];
                r_row[r]  <= 28'(r_part[r]) + 28'(r_p3[r]) + 28'(r_p4[r]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 4: registered row-sum combine (31 bits needed, 32 kept)
    // ------------------------------------------------------------------
    logic signed [31:0] w_acc;
    logic signed [31:0] r_acc;

    always_comb begin
        w_acc = '0;
        for (int r = 0; r < c_N; r++)
            w_acc = w_acc + 32'(r_row[r]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_acc <= '0;
        else     r_acc <= w_acc;
    end

    // ------------------------------------------------------------------
    // Stage 5: arithmetic shift by 8 (floor) and saturate to 0..255.
    // Dropping the low byte of a two's-complement value is a floor shift.
    // ------------------------------------------------------------------
    logic signed [23:0] w_res;
    logic        [7:0]  w_sat;

    assign w_res = r_acc[31:8];

    always_comb begin
        w_sat = w_res[7:0];
        if (w_res < 24'sd0)
            w_sat = 8'd0;
        else if (w_res > 24'sd255)
            w_sat = 8'd255;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) out_pixel <= '0;
        else     out_pixel <= w_sat;
    end

    // ------------------------------------------------------------------
    // Sideband: the first register samples on the same edge as the column
    // shift register. Five more registers follow, so the sideband leaves
    // on the same edge as out_pixel. Bit order: {valid, dv, hs, vs}.
    // ------------------------------------------------------------------
    logic [3:0] r_sb [c_N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_N; i++)
                r_sb[i] <= '0;
            {out_valid, dv_o, hs_o, vs_o} <= '0;
        end else begin
            r_sb[0] <= {in_valid, dv_i, hs_i, vs_i};
            for (int i = 1; i < c_N; i++)
                r_sb[i] <= r_sb[i-1];
            {out_valid, dv_o, hs_o, vs_o} <= r_sb[c_N-1];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cascade_systolic_fir.sv
`default_nettype none
// ============================================================================
// Module      : tb_cascade_systolic_fir
// Description : Scoreboard bench for cascade_systolic_fir. Each clock step
//               pushes the expected result of a window into a queue. The
//               entry is popped when the matching output appears 5 edges
//               later. Directed checks cover the worked kernel, saturation,
//               sideband alignment and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cascade_systolic_fir;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, dv_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;
    logic [7:0]  px [5];
    logic [15:0] k  [5][5];
    logic        out_valid, dv_o, hs_o, vs_o;
    logic [7:0]  out_pixel;

    always #5 clk = ~clk;

    cascade_systolic_fir dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
        .pixel0(px[0]), .pixel1(px[1]), .pixel2(px[2]), .pixel3(px[3]), .pixel4(px[4]),
        .coeff00(k[0][0]), .coeff01(k[0][1]), .coeff02(k[0][2]), .coeff03(k[0][3]), .coeff04(k[0][4]),
        .coeff10(k[1][0]), .coeff11(k[1][1]), .coeff12(k[1][2]), .coeff13(k[1][3]), .coeff14(k[1][4]),
        .coeff20(k[2][0]), .coeff21(k[2][1]), .coeff22(k[2][2]), .coeff23(k[2][3]), .coeff24(k[2][4]),
        .coeff30(k[3][0]), .coeff31(k[3][1]), .coeff32(k[3][2]), .coeff33(k[3][3]), .coeff34(k[3][4]),
        .coeff40(k[4][0]), .coeff41(k[4][1]), .coeff42(k[4][2]), .coeff43(k[4][3]), .coeff44(k[4][4]),
        .out_valid(out_valid), .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o),
        .out_pixel(out_pixel)
    );

    typedef struct {
        int         pix;
        logic [3:0] sb;
    } exp_t;

    exp_t       q [$];
    int         pw [5][5];   // model window [row][col], col 4 newest
    logic [3:0] ps;          // sideband sampled with the newest model column
    int         n_checks = 0;
    int         n_fail   = 0;
    int         step_no  = 0;

    // Kernel-1 columns: kc[col][row]
    int kc [5][5] = '{'{0,5,9,4,0}, '{1,6,8,3,1}, '{2,7,7,2,2}, '{3,8,6,1,3}, '{4,9,5,0,4}};

    task automatic check_eq(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Expected out_pixel of the model window under the coefficients now on the bus
    function automatic int model();
        int acc = 0;
        int res;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                acc += pw[r][c] * int'($signed(k[r][c]));
        res = acc >>> 8;
        if (res < 0)   return 0;
        if (res > 255) return 255;
        return res;
    endfunction

    // One clock: the edge samples the driven column. The products of the
    // previous window are formed on this same edge with the coefficients
    // currently driven, so that window's expectation is made here.
    task automatic step();
        exp_t e;
        @(posedge clk);
        step_no++;
        e.pix = model();
        e.sb  = ps;
        q.push_back(e);
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) pw[r][c] = pw[r][c+1];
            pw[r][4] = int'(px[r]);
        end
        ps = {in_valid, dv_i, hs_i, vs_i};
        #1;
        if (q.size() >= 5) begin
            e = q.pop_front();
            check_eq("out_pixel", int'(out_pixel), e.pix);
            check_eq("sideband", int'({out_valid, dv_o, hs_o, vs_o}), int'(e.sb));
        end
    endtask

    task automatic set_col(input int c);
        for (int r = 0; r < 5; r++) px[r] = 8'(kc[c][r]);
    endtask

    task automatic set_all_coeff(input logic [15:0] v);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) k[r][c] = v;
    endtask

    task automatic set_sb(input logic v);
        in_valid = v; dv_i = v; hs_i = v; vs_i = v;
    endtask

    // Holds reset over a few edges, then releases and reseeds the model
    // with the all-zero pipeline.
    task automatic do_reset();
        exp_t z;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) px[i] = '0;
        set_sb(1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) pw[r][c] = 0;
        ps = '0;
        z.pix = 0;
        z.sb  = '0;
        repeat (4) q.push_back(z);
        #1;
    endtask

    initial begin : main
        int first_hi;
        int cnt_hi;
        int s0;

        for (int i = 0; i < 5; i++) px[i] = '0;
        set_all_coeff(16'h0000);

        // Asynchronous reset takes effect without a clock edge
        #2 rst = 1'b1;
        #1;
        check_eq("reset_pixel", int'(out_pixel), 0);
        check_eq("reset_sideband", int'({out_valid, dv_o, hs_o, vs_o}), 0);
        do_reset();

        // Worked kernel: 75, then 46, then 19 on consecutive cycles
        set_all_coeff(16'hFF00);
        k[2][2] = 16'h1800;
        set_sb(1'b1);
        for (int c = 0; c < 5; c++) begin set_col(c); step(); end   // c4 sampled at step 5
        set_col(4); step();
        set_col(3); step();
        for (int i = 0; i < 5; i++) px[i] = '0;
        set_sb(1'b0);
        step(); step(); step();
        check_eq("kernel_75", int'(out_pixel), 75);
        check_eq("kernel_75_valid", int'(out_valid), 1);
        step();
        check_eq("kernel_46", int'(out_pixel), 46);
        step();
        check_eq("kernel_19", int'(out_pixel), 19);

        // Positive saturation
        for (int i = 0; i < 5; i++) px[i] = 8'd255;
        set_all_coeff(16'h0100);
        repeat (6) step();
        check_eq("sat_pos", int'(out_pixel), 255);

        // Negative saturation (coefficient change mid-stream)
        set_all_coeff(16'hFF00);
        repeat (6) step();
        check_eq("sat_neg", int'(out_pixel), 0);

        // Sideband alignment: high for 3 columns; pixels keep changing
        set_all_coeff(16'hFF00);
        k[2][2] = 16'h1800;
        first_hi = -1;
        cnt_hi   = 0;
        s0       = step_no + 1;
        for (int i = 0; i < 14; i++) begin
            set_sb(i < 3);
            for (int r = 0; r < 5; r++) px[r] = 8'($urandom_range(0, 40));
            step();
            if (out_valid) begin
                cnt_hi++;
                if (first_hi < 0) first_hi = step_no;
            end
        end
        check_eq("sb_first_edge", first_hi, s0 + 5);
        check_eq("sb_high_count", cnt_hi, 3);

        // Random pixels, coefficients and sideband, changing every cycle
        for (int i = 0; i < 40; i++) begin
            for (int r = 0; r < 5; r++) begin
                px[r] = 8'($urandom);
                for (int c = 0; c < 5; c++) k[r][c] = 16'($urandom_range(0, 16'h0300) - 16'h0180);
            end
            {in_valid, dv_i, hs_i, vs_i} = 4'($urandom);
            step();
        end

        // Reset mid-stream while outputs are non-zero
        for (int i = 0; i < 5; i++) px[i] = 8'd255;
        set_all_coeff(16'h0100);
        set_sb(1'b1);
        repeat (6) step();
        check_eq("pre_reset_pixel", int'(out_pixel), 255);
        set_all_coeff(16'hFF00);
        k[2][2] = 16'h1800;
        for (int c = 0; c < 3; c++) begin set_col(c); step(); end
        #2 rst = 1'b1;
        #1;
        check_eq("midreset_pixel", int'(out_pixel), 0);
        check_eq("midreset_sideband", int'({out_valid, dv_o, hs_o, vs_o}), 0);
        do_reset();
        set_all_coeff(16'h0100);
        repeat (7) begin
            step();
            check_eq("post_reset_pixel", int'(out_pixel), 0);
            check_eq("post_reset_valid", int'(out_valid), 0);
        end
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (6) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cascade_systolic_fir.md
CASCADE_SYSTOLIC_FIR -- requirements
Module: cascade_systolic_fir

Interface
REQ-001 SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input column qualifier.
- dv_i, hs_i, vs_i  in  1 each  video data-valid/hsync/vsync sideband.
- pixel0..pixel4  in  8 each  unsigned; one image column per clock; pixelR = window row R.
- coeffRC (R,C = 0..4; coeff00..coeff44)  in  16 each  signed Q8.8; R = row, C = column.
- out_valid  out  1  output qualifier.
- dv_o, hs_o, vs_o  out  1 each  delayed sideband.
- out_pixel  out  8  unsigned filtered pixel.
REQ-003 SHALL have no parameters; all widths are fixed as listed.

Function
REQ-004 SHALL sample pixel0..pixel4 every rising clk edge, regardless of in_valid.
- Samples go into a 5-deep column shift register per row (free-running).
REQ-005 SHALL form a 5x5 window from the 5 most recently sampled columns.
- Column index C=4 is the newest column; C=0 is the column sampled 4 edges earlier.
REQ-006 SHALL compute acc = sum over R,C of pixel(R,C) x coeffRC.
- Pixel is zero-extended; coefficient is 16-bit two's complement.
- Each product is 25-bit signed; acc is at least 30-bit signed with no overflow.
REQ-007 SHALL compute res = acc arithmetically shifted right by 8 (truncation toward minus infinity).
- out_pixel = 0 if res < 0; 255 if res > 255; otherwise res[7:0].
REQ-008 SHALL be implemented as a systolic cascade:
- registered multiplies;
- per-row cascaded adder chain across columns;
- registered row-sum combine;
- registered shift/saturate stage.
REQ-009 SHALL have a fixed latency of 5 clk edges.
- out_pixel updates 5 edges after the edge that samples the newest column of a window.
- The pipeline accepts one new window every cycle.
REQ-010 SHALL delay in_valid, dv_i, hs_i and vs_i through a 5-stage register pipeline.
- out_valid, dv_o, hs_o and vs_o stay aligned with the out_pixel whose newest column was sampled on the same edge.
REQ-011 in_valid SHALL only qualify out_valid; it SHALL NOT gate the datapath.
REQ-012 SHALL sample coefficients every cycle (no load handshake).
- A coefficient change affects every window whose products are computed after the change.
REQ-013 SHALL pass out_pixel unchanged through out_valid=0 cycles (always the current pipeline result).
REQ-014 SHALL have no backpressure: the block never stalls.

Reset
REQ-015 While rst=1, SHALL immediately clear to 0 (asynchronously):
- all column shift registers, product, sum and sideband pipeline registers;
- out_pixel, out_valid, dv_o, hs_o and vs_o.
REQ-016 After rst falls, the first 4 windows SHALL include zero columns from reset.
REQ-017 Reset asserted mid-stream SHALL discard all in-flight windows.
- No output reflects pre-reset data after release.

Verification
REQ-018 Bench SHALL cover the following directed scenarios:
- Kernel: coeff22=0x1800, all other coeffRC=0xFF00. Rows r0..r4 per column c0..c4 are (0,5,9,4,0),(1,6,8,3,1),(2,7,7,2,2),(3,8,6,1,3),(4,9,5,0,4). Stream c0,c1,c2,c3,c4 -> out_pixel=75 five edges after c4 is sampled.
- Same kernel, continue streaming c4 then c3 -> next two results are 46 (0x2E) then 19 (0x13) on consecutive cycles.
- Positive saturation: all pixels 255, all coeff 0x0100 -> out_pixel=255. Negative saturation: all coeff 0xFF00 -> out_pixel=0.
- Sideband alignment: in_valid/dv_i/hs_i/vs_i high for 3 columns then low -> the outputs are high for exactly the 3 cycles starting 5 edges later. out_pixel keeps updating afterwards.
- Reset mid-stream: assert rst during the kernel-1 stream -> all outputs are 0 at once. After release with all-zero pixels, out_pixel stays 0 and out_valid stays 0 until in_valid propagates.
